// File: rtl/pipe_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fwd_ctrl
// Purpose  : Operand forwarding and load-use interlock for an in-order pipe.
//            A shift-register tracker records the destination of every
//            instruction in flight (entry 0 = EX, youngest). Each decode
//            source is resolved against the youngest matching writer. The
//            operand comes from that stage's result when it is ready,
//            otherwise from the register file. Decode is stalled while the
//            youngest writer's value is not yet available.
// Ports    : Clk, Rst           - clock (rising edge), async active-low reset
//            id_*               - decode-stage instruction descriptor
//            flush              - squash the decode instruction this cycle
//            res_valid/res_data - per-stage result valid / value (packed)
//            rf_data1/2         - register-file read values
//            op1/op2            - resolved operands
//            fwd_sel1/2         - one-hot source select (bit0 = RF, k+1 = stage k)
//            stall, issue       - interlock / decode instruction accepted
//            stall_cnt          - saturating count of stalled cycles
// Revision : 1.0 - initial release
// ============================================================================
module pipe_fwd_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     id_valid,
    input  logic                     id_wen,
    input  logic                     id_is_load,
    input  logic [ADDR_W-1:0]        id_dst,
    input  logic [ADDR_W-1:0]        id_src1,
    input  logic [ADDR_W-1:0]        id_src2,
    input  logic                     id_src1_use,
    input  logic                     id_src2_use,
    input  logic                     flush,
    input  logic [STAGES-1:0]        res_valid,
    input  logic [STAGES*DATA_W-1:0] res_data,
    input  logic [DATA_W-1:0]        rf_data1,
    input  logic [DATA_W-1:0]        rf_data2,
    output logic [DATA_W-1:0]        op1,
    output logic [DATA_W-1:0]        op2,
    output logic [STAGES:0]          fwd_sel1,
    output logic [STAGES:0]          fwd_sel2,
    output logic                     stall,
    output logic                     issue,
    output logic [15:0]              stall_cnt
);

    // Tracker entries
    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_wen;
    logic [STAGES-1:0] r_load;
    logic [ADDR_W-1:0] r_dst [STAGES];

    logic              w_src1_ok;
    logic              w_src2_ok;
    logic [STAGES-1:0] w_rdy;
    logic [STAGES-1:0] w_hit1;
    logic [STAGES-1:0] w_hit2;
    logic [STAGES-1:0] w_first1;
    logic [STAGES-1:0] w_first2;
    logic [DATA_W-1:0] w_slice [STAGES];
    logic [DATA_W-1:0] w_fdata1;
    logic [DATA_W-1:0] w_fdata2;
    logic              w_fwd1;
    logic              w_fwd2;
    logic              w_blk1;
    logic              w_blk2;

    // A source that is not read, or that names the hardwired zero register,
    // can never match an in-flight writer.
    assign w_src1_ok = id_src1_use & ~((ZERO_REG != 0) && (id_src1 == '0));
    assign w_src2_ok = id_src2_use & ~((ZERO_REG != 0) && (id_src2 == '0));

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Loads have no data before LOAD_STAGE, whatever res_valid says.
        localparam logic c_EARLY = (k < LOAD_STAGE);

        assign w_slice[k] = res_data[k*DATA_W +: DATA_W];
        assign w_hit1[k]  = w_src1_ok & r_v[k] & r_wen[k] & (r_dst[k] == id_src1);
        assign w_hit2[k]  = w_src2_ok & r_v[k] & r_wen[k] & (r_dst[k] == id_src2);
        assign w_rdy[k]   = res_valid[k] & ~(r_load[k] & c_EARLY);
    end

    // Isolate the lowest set bit: the youngest writer shadows older ones.
    assign w_first1 = w_hit1 & (~w_hit1 + STAGES'(1));
    assign w_first2 = w_hit2 & (~w_hit2 + STAGES'(1));

    assign w_fwd1 = |(w_first1 & w_rdy);
    assign w_fwd2 = |(w_first2 & w_rdy);
    assign w_blk1 = |(w_first1 & ~w_rdy);
    assign w_blk2 = |(w_first2 & ~w_rdy);

    // AND-OR mux over stages; w_first* is at most one-hot.
    always_comb begin
        w_fdata1 = '0;
        w_fdata2 = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_fdata1 = w_fdata1 | ({DATA_W{w_first1[k]}} & w_slice[k]);
            w_fdata2 = w_fdata2 | ({DATA_W{w_first2[k]}} & w_slice[k]);
        end
    end

    // A blocked source falls back to the register-file select so the
    // select stays one-hot while stalled.
    assign op1      = w_fwd1 ? w_fdata1 : rf_data1;
    assign op2      = w_fwd2 ? w_fdata2 : rf_data2;
    assign fwd_sel1 = w_fwd1 ? {w_first1, 1'b0} : {{STAGES{1'b0}}, 1'b1};
    assign fwd_sel2 = w_fwd2 ? {w_first2, 1'b0} : {{STAGES{1'b0}}, 1'b1};

    // Flush overrides the interlock: a squashed instruction needs no operands.
    assign stall = id_valid & ~flush & (w_blk1 | w_blk2);
    assign issue = id_valid & ~flush & ~stall;

    // Entry 0 takes the decode instruction or a bubble; older entries keep
    // advancing even while decode is held.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_v    <= '0;
            r_wen  <= '0;
            r_load <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_dst[k] <= '0;
            end
        end else begin
            r_v[0]    <= issue;
            r_wen[0]  <= id_wen;
            r_load[0] <= id_is_load;
            r_dst[0]  <= id_dst;
            for (int k = 1; k < STAGES; k++) begin
                r_v[k]    <= r_v[k-1];
                r_wen[k]  <= r_wen[k-1];
                r_load[k] <= r_load[k-1];
                r_dst[k]  <= r_dst[k-1];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_fwd_ctrl
// Purpose  : Self-checking bench for pipe_fwd_ctrl. A list-of-instructions
//            reference model predicts operands, selects, stall and issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_fwd_ctrl;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int ST = 3;
    localparam int LS = 1;

    logic           Clk = 1'b0;
    logic           Rst = 1'b1;
    logic           id_valid, id_wen, id_is_load, id_src1_use, id_src2_use, flush;
    logic [AW-1:0]  id_dst, id_src1, id_src2;
    logic [ST-1:0]  res_valid;
    logic [ST*DW-1:0] res_data;
    logic [DW-1:0]  rf_data1, rf_data2, op1, op2;
    logic [ST:0]    fwd_sel1, fwd_sel2;
    logic           stall, issue;
    logic [15:0]    stall_cnt;

    pipe_fwd_ctrl #(.DATA_W(DW), .ADDR_W(AW), .STAGES(ST), .LOAD_STAGE(LS), .ZERO_REG(1)) dut (
        .Clk(Clk), .Rst(Rst),
        .id_valid(id_valid), .id_wen(id_wen), .id_is_load(id_is_load),
        .id_dst(id_dst), .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_use(id_src1_use), .id_src2_use(id_src2_use), .flush(flush),
        .res_valid(res_valid), .res_data(res_data),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .op1(op1), .op2(op2), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .stall(stall), .issue(issue), .stall_cnt(stall_cnt)
    );

    always #5 Clk = ~Clk;

    // Reference model: list of in-flight instructions, index = age in cycles
    logic [ST-1:0] m_v, m_wen, m_load;
    logic [AW-1:0] m_dst [ST];
    int            m_cnt;
    logic [DW-1:0] e_op1, e_op2;
    logic [ST:0]   e_sel1, e_sel2;
    logic          e_stall, e_issue;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic clear_model();
        m_v = '0; m_wen = '0; m_load = '0; m_cnt = 0;
        for (int k = 0; k < ST; k++) m_dst[k] = '0;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_wen = 0; id_is_load = 0; id_src1_use = 0; id_src2_use = 0;
        flush = 0; id_dst = '0; id_src1 = '0; id_src2 = '0;
        res_valid = '0; res_data = '0; rf_data1 = '0; rf_data2 = '0;
    endtask

    // Find the youngest in-flight writer of src; forward it if its value exists.
    function automatic void resolve(input logic use_, input logic [AW-1:0] src,
                                    input logic [DW-1:0] rf, output logic [DW-1:0] op,
                                    output logic [ST:0] sel, output logic blk);
        int y = -1;
        op = rf; sel = 4'b0001; blk = 1'b0;
        if (use_ && src != 0)
            for (int k = 0; k < ST; k++)
                if (y < 0 && m_v[k] && m_wen[k] && m_dst[k] == src) y = k;
        if (y >= 0) begin
            if (res_valid[y] && !(m_load[y] && y < LS)) begin
                op  = res_data[y*DW +: DW];
                sel = 4'(1 << (y + 1));
            end else begin
                blk = 1'b1;
            end
        end
    endfunction

    task automatic model_eval();
        logic b1, b2;
        resolve(id_src1_use, id_src1, rf_data1, e_op1, e_sel1, b1);
        resolve(id_src2_use, id_src2, rf_data2, e_op2, e_sel2, b2);
        e_stall = id_valid && !flush && (b1 || b2);
        e_issue = id_valid && !flush && !e_stall;
    endtask

    task automatic tick();
        model_eval();
        @(posedge Clk);
        if (Rst) begin
            for (int k = ST - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_wen[k] = m_wen[k-1];
                m_load[k] = m_load[k-1]; m_dst[k] = m_dst[k-1];
            end
            m_v[0] = e_issue; m_wen[0] = id_wen; m_load[0] = id_is_load; m_dst[0] = id_dst;
            if (e_stall && m_cnt < 65535) m_cnt++;
        end
        #1;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        clear_model();
        clear_inputs();
        @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        clear_model();
        #1 Rst = 1'b0;
        rf_data1 = 16'hA5A5; rf_data2 = 16'h5A5A;
        id_valid = 1; id_src1 = 4'd3; id_src1_use = 1; res_valid = '1;
        settle();
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (fwd_sel1 !== 4'b0001) begin n_bad++; $display("FAIL reset_sel1: got %b want 0001", fwd_sel1); end
        n_cmp++; if (fwd_sel2 !== 4'b0001) begin n_bad++; $display("FAIL reset_sel2: got %b want 0001", fwd_sel2); end
        n_cmp++; if (op1 !== 16'hA5A5) begin n_bad++; $display("FAIL reset_op1: got %h want a5a5", op1); end
        n_cmp++; if (op2 !== 16'h5A5A) begin n_bad++; $display("FAIL reset_op2: got %h want 5a5a", op2); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_alu_b2b();
        do_reset();
        id_valid = 1; id_wen = 1; id_dst = 4'd3;
        tick();
        id_wen = 0; id_dst = 0; id_src1 = 4'd3; id_src1_use = 1;
        res_valid = 3'b001; res_data = {16'h0, 16'h0, 16'h1234}; rf_data1 = 16'h5555;
        settle();
        n_cmp++; if (op1 !== 16'h1234) begin n_bad++; $display("FAIL b2b_op1: got %h want 1234", op1); end
        n_cmp++; if (fwd_sel1 !== 4'b0010) begin n_bad++; $display("FAIL b2b_sel1: got %b want 0010", fwd_sel1); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: got %b want 0", stall); end
    endtask

    task automatic test_load_use();
        do_reset();
        id_valid = 1; id_wen = 1; id_is_load = 1; id_dst = 4'd5;
        tick();
        id_wen = 0; id_is_load = 0; id_dst = 0; id_src2 = 4'd5; id_src2_use = 1; res_valid = '0;
        settle();
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", stall); end
        n_cmp++; if (fwd_sel2 !== 4'b0001) begin n_bad++; $display("FAIL lu_sel_stalled: got %b want 0001", fwd_sel2); end
        tick();
        n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
        res_valid = 3'b010; res_data = {16'h0, 16'hBEEF, 16'h0};
        settle();
        n_cmp++; if (op2 !== 16'hBEEF) begin n_bad++; $display("FAIL lu_op2: got %h want beef", op2); end
        n_cmp++; if (fwd_sel2 !== 4'b0100) begin n_bad++; $display("FAIL lu_sel2: got %b want 0100", fwd_sel2); end
        n_cmp++; if (issue !== 1'b1) begin n_bad++; $display("FAIL lu_issue: got %b want 1", issue); end
    endtask

    task automatic test_priority();
        do_reset();
        id_valid = 1; id_wen = 1;
        id_dst = 4'd2; tick();
        id_dst = 4'd4; tick();
        id_dst = 4'd2; tick();
        id_wen = 0; id_dst = 0; id_src1 = 4'd2; id_src1_use = 1;
        res_valid = 3'b111; res_data = {16'h0002, 16'h0009, 16'h0001};
        settle();
        n_cmp++; if (op1 !== 16'h0001) begin n_bad++; $display("FAIL prio_op1: got %h want 0001", op1); end
        n_cmp++; if (fwd_sel1 !== 4'b0010) begin n_bad++; $display("FAIL prio_sel1: got %b want 0010", fwd_sel1); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        id_valid = 1; id_wen = 1; id_dst = 4'd0;
        tick();
        id_wen = 0; id_src1 = 4'd0; id_src1_use = 1; rf_data1 = 16'hABCD;
        res_valid = 3'b111; res_data = {16'h1111, 16'h2222, 16'h3333};
        settle();
        n_cmp++; if (op1 !== 16'hABCD) begin n_bad++; $display("FAIL zero_op1: got %h want abcd", op1); end
        n_cmp++; if (fwd_sel1 !== 4'b0001) begin n_bad++; $display("FAIL zero_sel1: got %b want 0001", fwd_sel1); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL zero_stall: got %b want 0", stall); end
    endtask

    task automatic test_flush();
        do_reset();
        id_valid = 1; id_wen = 1; id_is_load = 1; id_dst = 4'd6;
        tick();
        id_is_load = 0; id_dst = 4'd7; id_src1 = 4'd6; id_src1_use = 1; flush = 1;
        settle();
        n_cmp++; if (issue !== 1'b0) begin n_bad++; $display("FAIL flush_issue: got %b want 0", issue); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", stall); end
        tick();
        flush = 0; id_wen = 0; id_dst = 0; id_src1 = 4'd7; res_valid = 3'b111;
        settle();
        n_cmp++; if (fwd_sel1 !== 4'b0001) begin n_bad++; $display("FAIL flush_sel1: got %b want 0001", fwd_sel1); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        // Two load-use episodes: 3 stalls, then 2 stalls
        id_valid = 1; id_wen = 1; id_is_load = 1; id_dst = 4'd9;
        tick();
        id_wen = 0; id_is_load = 0; id_dst = 0; id_src1 = 4'd9; id_src1_use = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mid_stall_a%0d: got %b want 1", i, stall); end
            tick();
        end
        id_src1_use = 0; id_wen = 1; id_is_load = 1; id_dst = 4'd9;
        tick();
        id_wen = 0; id_is_load = 0; id_dst = 0; id_src1_use = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mid_stall_b%0d: got %b want 1", i, stall); end
            tick();
        end
        id_src1_use = 0; id_wen = 1;
        for (int d = 1; d <= 3; d++) begin
            id_dst = AW'(d);
            tick();
        end
        n_cmp++; if (stall_cnt !== 16'd5) begin n_bad++; $display("FAIL mid_cnt5: got %0d want 5", stall_cnt); end
        id_wen = 0; id_dst = 0; id_src1 = 4'd3; id_src1_use = 1; res_valid = '0; rf_data1 = 16'h7777;
        settle();
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mid_prestall: got %b want 1", stall); end
        #2 Rst = 1'b0;
        clear_model();
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mid_rst_stall: got %b want 0", stall); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_rst_cnt: got %0d want 0", stall_cnt); end
        n_cmp++; if (op1 !== 16'h7777) begin n_bad++; $display("FAIL mid_rst_op1: got %h want 7777", op1); end
        #1 Rst = 1'b1;
        tick();
        settle();
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mid_after_stall: got %b want 0", stall); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_after_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            id_valid    = ($urandom_range(0, 9) < 8);
            id_wen      = ($urandom_range(0, 3) != 0);
            id_is_load  = ($urandom_range(0, 2) == 0);
            id_dst      = AW'($urandom_range(0, 3));
            id_src1     = AW'($urandom_range(0, 3));
            id_src2     = AW'($urandom_range(0, 3));
            id_src1_use = $urandom_range(0, 1);
            id_src2_use = $urandom_range(0, 1);
            flush       = ($urandom_range(0, 7) == 0);
            res_valid   = ST'($urandom);
            res_data    = 48'({$urandom(), $urandom()});
            rf_data1    = DW'($urandom);
            rf_data2    = DW'($urandom);
            settle();
            n_cmp++; if (op1 !== e_op1) begin n_bad++; $display("FAIL rnd_op1 c%0d: got %h want %h", c, op1, e_op1); end
            n_cmp++; if (op2 !== e_op2) begin n_bad++; $display("FAIL rnd_op2 c%0d: got %h want %h", c, op2, e_op2); end
            n_cmp++; if (fwd_sel1 !== e_sel1) begin n_bad++; $display("FAIL rnd_sel1 c%0d: got %b want %b", c, fwd_sel1, e_sel1); end
            n_cmp++; if (fwd_sel2 !== e_sel2) begin n_bad++; $display("FAIL rnd_sel2 c%0d: got %b want %b", c, fwd_sel2, e_sel2); end
            n_cmp++; if (stall !== e_stall) begin n_bad++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall, e_stall); end
            n_cmp++; if (issue !== e_issue) begin n_bad++; $display("FAIL rnd_issue c%0d: got %b want %b", c, issue, e_issue); end
            n_cmp++; if (stall_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, stall_cnt, m_cnt); end
            if ($urandom_range(0, 59) == 0) begin
                #2 Rst = 1'b0;
                clear_model();
                #1;
                n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL rnd_rst_cnt c%0d: got %0d want 0", c, stall_cnt); end
                #1 Rst = 1'b1;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alu_b2b();
        test_load_use();
        test_priority();
        test_zero_reg();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
